// File: rtl/q_enable_sequencer.sv
// One-hot enable sequencer for Q-table / action register enables.
// Registered outputs, valid/ready request handshake, PULSE / HOLD / SCAN modes.
module q_enable_sequencer #(
  parameter  int unsigned SEL_W = 4,
  localparam int unsigned N_OUT = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] scan_end,
  input  logic             adv,
  input  logic             clr,
  output logic [N_OUT-1:0] en,
  output logic [SEL_W-1:0] idx,
  output logic             en_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_HOLD  = 2'd2,
    S_SCAN  = 2'd3
  } state_e;

  state_e           state_q;
  logic [N_OUT-1:0] en_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] scan_end_q;
  logic             en_valid_q;
  logic             done_q;
  logic             req_ready_q;

  // PULSE doubles as the "final enable cycle" state: HOLD release and SCAN
  // completion pass through it so done lands together with the last enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      en_q        <= '0;
      idx_q       <= '0;
      scan_end_q  <= '0;
      en_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            en_q        <= N_OUT'(1) << sel;
            idx_q       <= sel;
            scan_end_q  <= scan_end;
            en_valid_q  <= 1'b1;
            req_ready_q <= 1'b0;
            case (mode)
              2'b01:   state_q <= S_HOLD;
              2'b10:   state_q <= S_SCAN;
              default: begin
                state_q <= S_PULSE;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        S_PULSE: begin
          en_q        <= '0;
          en_valid_q  <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_HOLD: begin
          if (clr) begin
            done_q  <= 1'b1;
            state_q <= S_PULSE;
          end
        end
        S_SCAN: begin
          // Abort beats advance; an aborted scan never reports done.
          if (clr) begin
            en_q        <= '0;
            en_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (adv) begin
            if (idx_q == scan_end_q) begin
              done_q  <= 1'b1;
              state_q <= S_PULSE;
            end else begin
              idx_q <= idx_q + SEL_W'(1);
              en_q  <= {en_q[N_OUT-2:0], en_q[N_OUT-1]};
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign en        = en_q;
  assign idx       = idx_q;
  assign en_valid  = en_valid_q;
  assign done      = done_q;
  assign req_ready = req_ready_q;

endmodule

// File: tb/tb_q_enable_sequencer.sv
// Self-checking bench for q_enable_sequencer: directed scenarios plus random
// transactions checked against a queue-based model of the enable sequence.
module tb_q_enable_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, adv, clr, en_valid, done;
  logic [3:0]  sel, scan_end, idx;
  logic [1:0]  mode;
  logic [15:0] en;

  logic        req_valid3, req_ready3, adv3, clr3, en_valid3, done3;
  logic [2:0]  sel3, scan_end3, idx3;
  logic [1:0]  mode3;
  logic [7:0]  en3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  q_enable_sequencer #(.SEL_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .sel(sel), .mode(mode), .scan_end(scan_end), .adv(adv), .clr(clr),
    .en(en), .idx(idx), .en_valid(en_valid), .done(done)
  );

  q_enable_sequencer #(.SEL_W(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .sel(sel3), .mode(mode3), .scan_end(scan_end3), .adv(adv3), .clr(clr3),
    .en(en3), .idx(idx3), .en_valid(en_valid3), .done(done3)
  );

  // Observed tuple: {en, idx, done, en_valid, req_ready}
  function automatic logic [22:0] exp_active(input logic [3:0] i, input logic d);
    return {16'(1) << i, i, d, 1'b1, 1'b0};
  endfunction

  function automatic logic [22:0] exp_idle(input logic [3:0] i);
    return {16'h0000, i, 1'b0, 1'b0, 1'b1};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({en, idx, done, en_valid, req_ready} !== exp_idle(4'd0)) begin
      n_fail++;
      $display("FAIL reset got=%h exp=%h", {en, idx, done, en_valid, req_ready}, exp_idle(4'd0));
    end
    n_checks++;
    if ({en3, idx3, done3, en_valid3, req_ready3} !== {8'h00, 3'd0, 3'b001}) begin
      n_fail++;
      $display("FAIL reset3 got=%h exp=%h", {en3, idx3, done3, en_valid3, req_ready3}, {8'h00, 3'd0, 3'b001});
    end
  endtask

  task automatic test_pulse(input logic [3:0] s, input logic [1:0] m);
    req_valid = 1'b1; sel = s; mode = m;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if ({en, idx, done, en_valid, req_ready} !== exp_active(s, 1'b1)) begin
      n_fail++;
      $display("FAIL pulse_en sel=%0d mode=%0d got=%h exp=%h", s, m, {en, idx, done, en_valid, req_ready}, exp_active(s, 1'b1));
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({en, idx, done, en_valid, req_ready} !== exp_idle(s)) begin
        n_fail++;
        $display("FAIL pulse_idle c=%0d got=%h exp=%h", c, {en, idx, done, en_valid, req_ready}, exp_idle(s));
      end
    end
  endtask

  task automatic test_hold(input logic [3:0] s, input int wait_cyc, input bit intrude);
    req_valid = 1'b1; sel = s; mode = 2'b01;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < wait_cyc; c++) begin
      n_checks++;
      if ({en, idx, done, en_valid, req_ready} !== exp_active(s, 1'b0)) begin
        n_fail++;
        $display("FAIL hold_wait c=%0d got=%h exp=%h", c, {en, idx, done, en_valid, req_ready}, exp_active(s, 1'b0));
      end
      if (intrude) begin
        req_valid = 1'b1; sel = s + 4'd1; mode = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if ({en, idx, done, en_valid, req_ready} !== exp_active(s, 1'b1)) begin
      n_fail++;
      $display("FAIL hold_done got=%h exp=%h", {en, idx, done, en_valid, req_ready}, exp_active(s, 1'b1));
    end
    @(negedge clk);
    n_checks++;
    if ({en, idx, done, en_valid, req_ready} !== exp_idle(s)) begin
      n_fail++;
      $display("FAIL hold_release got=%h exp=%h", {en, idx, done, en_valid, req_ready}, exp_idle(s));
    end
  endtask

  // The model is the list of indices still to visit; adv pops it, an adv on the
  // last entry completes, clr/rst abort at the requested index.
  task automatic test_scan(input logic [3:0] s, input logic [3:0] e, input logic [31:0] pat,
                           input int npat, input bit rnd_adv, input int abort_idx, input bit abort_rst);
    logic [3:0]  path[$];
    logic [3:0]  span;
    logic [3:0]  last_i;
    logic [22:0] exp;
    logic        a;
    int          cyc;
    bit          finished;
    path = {};
    span = e - s;
    for (int k = 0; k <= int'(span); k++) path.push_back(s + 4'(k));
    req_valid = 1'b1; sel = s; scan_end = e; mode = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    finished = 1'b0;
    while (!finished && cyc < 200) begin
      exp = exp_active(path[0], 1'b0);
      n_checks++;
      if ({en, idx, done, en_valid, req_ready} !== exp) begin
        n_fail++;
        $display("FAIL scan_step s=%0d e=%0d cyc=%0d got=%h exp=%h", s, e, cyc, {en, idx, done, en_valid, req_ready}, exp);
      end
      a = (cyc < npat) ? pat[cyc] : (rnd_adv ? 1'($urandom_range(0, 1)) : 1'b1);
      if (abort_idx >= 0 && int'(path[0]) == abort_idx) begin
        last_i = path[0];
        if (abort_rst) rst = 1'b1; else clr = 1'b1;
        adv = 1'b1;
        @(negedge clk);
        rst = 1'b0; clr = 1'b0; adv = 1'b0;
        exp = abort_rst ? exp_idle(4'd0) : exp_idle(last_i);
        for (int c = 0; c < 2; c++) begin
          n_checks++;
          if ({en, idx, done, en_valid, req_ready} !== exp) begin
            n_fail++;
            $display("FAIL scan_abort rst=%0b c=%0d got=%h exp=%h", abort_rst, c, {en, idx, done, en_valid, req_ready}, exp);
          end
          @(negedge clk);
        end
        finished = 1'b1;
      end else begin
        adv = a;
        @(negedge clk);
        adv = 1'b0;
        if (a) begin
          if (path.size() == 1) begin
            last_i = path[0];
            n_checks++;
            if ({en, idx, done, en_valid, req_ready} !== exp_active(last_i, 1'b1)) begin
              n_fail++;
              $display("FAIL scan_done got=%h exp=%h", {en, idx, done, en_valid, req_ready}, exp_active(last_i, 1'b1));
            end
            @(negedge clk);
            n_checks++;
            if ({en, idx, done, en_valid, req_ready} !== exp_idle(last_i)) begin
              n_fail++;
              $display("FAIL scan_end_idle got=%h exp=%h", {en, idx, done, en_valid, req_ready}, exp_idle(last_i));
            end
            finished = 1'b1;
          end else begin
            void'(path.pop_front());
          end
        end
      end
      cyc++;
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL scan_timeout s=%0d e=%0d cycles=%0d", s, e, cyc);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; sel = 4'd3; mode = 2'b00;
    @(negedge clk);
    sel = 4'd9;
    n_checks++;
    if ({en, idx, done, en_valid, req_ready} !== exp_active(4'd3, 1'b1)) begin
      n_fail++;
      $display("FAIL b2b_first got=%h exp=%h", {en, idx, done, en_valid, req_ready}, exp_active(4'd3, 1'b1));
    end
    @(negedge clk);
    n_checks++;
    if ({en, idx, done, en_valid, req_ready} !== exp_idle(4'd3)) begin
      n_fail++;
      $display("FAIL b2b_ignored got=%h exp=%h", {en, idx, done, en_valid, req_ready}, exp_idle(4'd3));
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if ({en, idx, done, en_valid, req_ready} !== exp_active(4'd9, 1'b1)) begin
      n_fail++;
      $display("FAIL b2b_second got=%h exp=%h", {en, idx, done, en_valid, req_ready}, exp_active(4'd9, 1'b1));
    end
    @(negedge clk);
  endtask

  task automatic test_sel_w3();
    req_valid3 = 1'b1; sel3 = 3'd7; mode3 = 2'b00;
    @(negedge clk);
    req_valid3 = 1'b0;
    n_checks++;
    if ({en3, idx3, done3, en_valid3, req_ready3} !== {8'h80, 3'd7, 3'b110}) begin
      n_fail++;
      $display("FAIL selw3_pulse got=%h exp=%h", {en3, idx3, done3, en_valid3, req_ready3}, {8'h80, 3'd7, 3'b110});
    end
    @(negedge clk);
    n_checks++;
    if ({en3, idx3, done3, en_valid3, req_ready3} !== {8'h00, 3'd7, 3'b001}) begin
      n_fail++;
      $display("FAIL selw3_idle got=%h exp=%h", {en3, idx3, done3, en_valid3, req_ready3}, {8'h00, 3'd7, 3'b001});
    end
  endtask

  task automatic test_random(input int n);
    logic [3:0] s, e, span;
    int         kind, ab;
    for (int t = 0; t < n; t++) begin
      kind = int'($urandom_range(0, 3));
      s    = 4'($urandom_range(0, 15));
      e    = 4'($urandom_range(0, 15));
      span = e - s;
      case (kind)
        0: test_pulse(s, 2'b00);
        1: test_pulse(s, 2'b11);
        2: test_hold(s, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        default: begin
          ab = ($urandom_range(0, 3) == 0) ? int'(4'(s + 4'($urandom_range(0, int'(span))))) : -1;
          test_scan(s, e, 32'h0, 0, 1'b1, ab, 1'($urandom_range(0, 1)));
        end
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; sel = '0; mode = '0; scan_end = '0; adv = 1'b0; clr = 1'b0;
    req_valid3 = 1'b0; sel3 = '0; mode3 = '0; scan_end3 = '0; adv3 = 1'b0; clr3 = 1'b0;
    test_reset();
    test_pulse(4'd5, 2'b00);
    test_pulse(4'd0, 2'b11);
    test_hold(4'd15, 10, 1'b1);
    test_scan(4'd2, 4'd6, 32'b1101101, 7, 1'b0, -1, 1'b0);
    test_scan(4'd14, 4'd1, 32'h0, 0, 1'b0, -1, 1'b0);
    test_scan(4'd7, 4'd7, 32'h0, 0, 1'b0, -1, 1'b0);
    test_scan(4'd0, 4'd15, 32'h0, 0, 1'b0, 4, 1'b0);
    test_scan(4'd0, 4'd15, 32'h0, 0, 1'b0, 9, 1'b1);
    test_back_to_back();
    test_sel_w3();
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
